cpu_io_bus_sequencer: RTL
=========================

Name: cpu_io_bus_sequencer

Overview:
CPU-side master for the board's I/O port bus. It issues the IN0..IN4 read strobes and the OUT1/OUT2 write strobes, and places data on or samples data from the shared 8-bit data bus DB0..DB7. It converts a single-cycle request/response interface from the CPU core into timed active-low port strobes with setup, strobe and hold phases. It also generates CLR_AL for the LS175 output latches.

Parameters:
SETUP_CYC, 1, cycles from address/data valid to strobe assertion; 0 skips the SETUP state.
STROBE_CYC, 2, cycles the port strobe is held low; must be at least 1.
HOLD_CYC, 1, cycles the write data (DB_OE) is held after the strobe rises; 0 skips the HOLD state.
CLR_CYC, 4, cycles CLR_AL stays low after RESET deasserts; must be at least 1.

Ports:
CLK  in  1  system clock; all state changes on its rising edge.
RESET  in  1  asynchronous, active-high reset.
REQ_VALID  in  1  request present.
REQ_READY  out  1  sequencer can accept a request.
REQ_WRITE  in  1  1 = write to an OUT port, 0 = read from an IN port.
REQ_PORT  in  3  port select: 0-4 = IN0..IN4, 5 = OUT1, 6 = OUT2, 7 = reserved.
REQ_WDATA  in  8  write data.
RSP_VALID  out  1  one-cycle pulse marking request completion.
RSP_RDATA  out  8  read data; valid when RSP_VALID is high.
RSP_ERR  out  1  illegal request flag; valid when RSP_VALID is high.
DB_IN  in  8  data bus value as seen by the CPU.
DB_OUT  out  8  data driven onto the bus.
DB_OE  out  1  bus drive enable; the top level builds the tri-state from DB_OUT and DB_OE.
IN0_AL..IN4_AL  out  1 each  active-low read strobes.
OUT1_AL, OUT2_AL  out  1 each  active-low write strobes.
CLR_AL  out  1  active-low latch clear.

Behaviour:
- Reset values: all strobes 1; CLR_AL 0; DB_OE 0; DB_OUT 0; REQ_READY 0; RSP_VALID 0; RSP_RDATA 0; RSP_ERR 0; state IDLE.
- CLR_AL stays 0 while RESET is high and for CLR_CYC cycles after RESET falls, then goes to 1.
- REQ_READY is 1 only when the state is IDLE and CLR_AL is 1. It is registered.
- A request is accepted on any edge where REQ_VALID and REQ_READY are both 1. REQ_PORT, REQ_WRITE and REQ_WDATA are captured at that edge. At most one transaction is outstanding.
- Legal requests are reads of ports 0-4 and writes of ports 5-6. Every other combination is illegal.
  - Illegal request: go directly to RESP. Response is RSP_ERR = 1, RSP_RDATA = 0, RSP_VALID pulses one cycle after acceptance. No strobe and no bus drive occur.
- States and transitions: IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE.
  - SETUP is skipped when SETUP_CYC = 0.
  - HOLD is skipped when HOLD_CYC = 0.
  - A single down-counter, reloaded at each state entry, times SETUP, STROBE and HOLD.
- Strobe: exactly one strobe is low, and only during STROBE, for exactly STROBE_CYC cycles. All strobe outputs are registered and glitch-free.
- Write:
  - DB_OUT = captured data and DB_OE = 1 from the first SETUP cycle (or the first STROBE cycle if SETUP is skipped) through the last HOLD cycle.
  - The latch captures on the strobe's rising edge, which therefore always falls inside the DB_OE window.
  - RSP_RDATA = 0 for writes.
- Read:
  - DB_OE stays 0 for the whole transaction.
  - DB_IN is sampled on the clock edge that ends the last STROBE cycle, while the strobe is still low.
  - The sampled value is held in RSP_RDATA until the next response.
- Response: RSP_VALID is high for exactly one cycle in RESP; there is no backpressure. REQ_READY returns to 1 in the cycle after RESP.
- Latency with default parameters: acceptance at edge 0; strobe low in cycles 2-3; RSP_VALID in cycle 5; next acceptance possible at edge 6. In general the response arrives 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after acceptance.
- Reset mid-transaction: strobes rise and DB_OE drops immediately (asynchronously), and no response is issued.

Decomposition:
- Shared package (cpu_io_pkg):
  - state enum: IDLE, SETUP, STROBE, HOLD, RESP.
  - port-number constants: PORT_IN0..PORT_IN4, PORT_OUT1, PORT_OUT2.
  - function is_legal(write, port).
- One natural sub-module: cpu_io_strobe_decode, a registered one-hot strobe decoder (port and strobe-enable in, seven active-low strobes out).

Test Plan:
- Reset release: CLR_AL low for 4 cycles after RESET falls; REQ_READY is 0 during that window and 1 afterwards; all strobes stay at 1.
- Read port 2 with DB_IN = 8'hA5: IN2_AL is low for exactly 2 cycles; RSP_VALID appears 5 cycles after acceptance with RSP_RDATA = 8'hA5 and RSP_ERR = 0; DB_OE stays 0 throughout.
- Write port 6 with data 8'h3C: DB_OE = 1 with DB_OUT = 8'h3C for 4 cycles; OUT2_AL is low in the middle 2 cycles; an attached LS175 model captures 8'h3C on the OUT2_AL rising edge.
- Illegal requests (write port 1, read port 5, port 7): RSP_VALID appears 1 cycle after acceptance with RSP_ERR = 1; no strobe and no DB_OE.
- Back-to-back: REQ_VALID held high for a read of port 0 then a write of port 5; the second request is accepted exactly 1 cycle after the first RSP_VALID; strobes never overlap.
- RESET asserted during STROBE of a write of port 5: OUT1_AL and DB_OE return to their reset values before the next edge; no RSP_VALID; CLR_AL is low.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared types, port numbers and the request legality rule for the CPU I/O
// port bus sequencer.
package cpu_io_pkg;

    localparam int CNT_W       = 8;
    localparam int NUM_STROBES = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam logic [2:0] PORT_IN0  = 3'd0;
    localparam logic [2:0] PORT_IN1  = 3'd1;
    localparam logic [2:0] PORT_IN2  = 3'd2;
    localparam logic [2:0] PORT_IN3  = 3'd3;
    localparam logic [2:0] PORT_IN4  = 3'd4;
    localparam logic [2:0] PORT_OUT1 = 3'd5;
    localparam logic [2:0] PORT_OUT2 = 3'd6;

    // Reads may target IN0..IN4 only, writes OUT1/OUT2 only.
    function automatic logic is_legal(input logic write, input logic [2:0] port);
        logic legal;
        if (write) begin
            legal = (port == PORT_OUT1) || (port == PORT_OUT2);
        end else begin
            legal = (port <= PORT_IN4);
        end
        return legal;
    endfunction

endpackage

// File: rtl/cpu_io_bus_sequencer_if.sv
// CPU request/response channel plus the I/O port bus pins. The master view
// belongs to the sequencer; the slave view is the CPU core and the board.
interface cpu_io_bus_sequencer_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [2:0] req_port;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       db_oe;
    logic       in0_al;
    logic       in1_al;
    logic       in2_al;
    logic       in3_al;
    logic       in4_al;
    logic       out1_al;
    logic       out2_al;
    logic       clr_al;

    modport master (
        input  req_valid, req_write, req_port, req_wdata, db_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, db_out, db_oe,
        output in0_al, in1_al, in2_al, in3_al, in4_al, out1_al, out2_al, clr_al
    );

    modport slave (
        output req_valid, req_write, req_port, req_wdata, db_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, db_out, db_oe,
        input  in0_al, in1_al, in2_al, in3_al, in4_al, out1_al, out2_al, clr_al
    );

endinterface

// File: rtl/cpu_io_strobe_decode.sv
// Registered one-hot decoder: drives at most one active-low port strobe,
// straight from flops so the strobe pins never glitch.
module cpu_io_strobe_decode
    import cpu_io_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             port,
    input  logic                   strobe_en,
    output logic [NUM_STROBES-1:0] strobe_al
);

    logic [NUM_STROBES-1:0] strobe_al_s;
    logic [NUM_STROBES-1:0] strobe_al_r;

    // Select the single strobe to pull low for the coming cycle.
    always_comb begin
        strobe_al_s = 7'h7F;
        if (strobe_en) begin
            case (port)
                PORT_IN0:  strobe_al_s = 7'b111_1110;
                PORT_IN1:  strobe_al_s = 7'b111_1101;
                PORT_IN2:  strobe_al_s = 7'b111_1011;
                PORT_IN3:  strobe_al_s = 7'b111_0111;
                PORT_IN4:  strobe_al_s = 7'b110_1111;
                PORT_OUT1: strobe_al_s = 7'b101_1111;
                PORT_OUT2: strobe_al_s = 7'b011_1111;
                default:   strobe_al_s = 7'h7F;
            endcase
        end else begin
            strobe_al_s = 7'h7F;
        end
    end

    // Strobe flops; reset forces every strobe inactive immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_al_r <= 7'h7F;
        end else begin
            strobe_al_r <= strobe_al_s;
        end
    end

    assign strobe_al = strobe_al_r;

endmodule

// File: rtl/cpu_io_bus_sequencer.sv
// CPU-side master for the I/O port bus: turns one request into a timed
// setup / strobe / hold sequence on an active-low port strobe, drives or
// samples the data bus, and releases the LS175 latch clear after reset.
module cpu_io_bus_sequencer
    import cpu_io_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned CLR_CYC    = 4
)(
    input logic                    clk,
    input logic                    rst,
    cpu_io_bus_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    // Counters load N-1 on entry and the phase ends when they reach zero.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 32'd1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CLR_LD    = CNT_W'(CLR_CYC - 32'd1);

    state_e                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             port_r;
    logic                   write_r;
    logic [7:0]             db_out_r;
    logic                   db_oe_r;
    logic                   req_ready_r;
    logic                   rsp_valid_r;
    logic [7:0]             rsp_rdata_r;
    logic                   rsp_err_r;
    logic [CNT_W-1:0]       clr_cnt_r;
    logic                   clr_al_r;

    logic                   accept_s;
    logic                   legal_s;
    logic                   clr_next_s;
    logic                   strobe_next_s;
    logic [2:0]             dec_port_s;
    logic [NUM_STROBES-1:0] strobe_al_s;

    // Acceptance, legality and whether the next cycle is a strobe cycle.
    always_comb begin
        accept_s      = bus.req_valid && req_ready_r;
        legal_s       = is_legal(bus.req_write, bus.req_port);
        clr_next_s    = clr_al_r || (clr_cnt_r == CNT_ZERO);
        dec_port_s    = port_r;
        strobe_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                // With no setup phase the strobe starts right after acceptance,
                // before the port has been captured.
                dec_port_s = bus.req_port;
                if (accept_s && legal_s && (SETUP_CYC == 32'd0)) begin
                    strobe_next_s = 1'b1;
                end else begin
                    strobe_next_s = 1'b0;
                end
            end
            SETUP:   strobe_next_s = (cnt_r == CNT_ZERO);
            STROBE:  strobe_next_s = (cnt_r != CNT_ZERO);
            default: strobe_next_s = 1'b0;
        endcase
    end

    // Latch-clear release timer, restarted by every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_r <= CLR_LD;
            clr_al_r  <= 1'b0;
        end else if (clr_cnt_r == CNT_ZERO) begin
            clr_al_r  <= 1'b1;
        end else begin
            clr_cnt_r <= clr_cnt_r - CNT_ONE;
            clr_al_r  <= 1'b0;
        end
    end

    // Transaction sequencer with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            port_r      <= 3'd0;
            write_r     <= 1'b0;
            db_out_r    <= 8'h00;
            db_oe_r     <= 1'b0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        port_r      <= bus.req_port;
                        write_r     <= bus.req_write;
                        req_ready_r <= 1'b0;
                        if (!legal_s) begin
                            // Illegal: answer at once, never touch the bus.
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 8'h00;
                        end else begin
                            if (bus.req_write) begin
                                db_out_r <= bus.req_wdata;
                                db_oe_r  <= 1'b1;
                            end
                            if (SETUP_CYC != 32'd0) begin
                                state_r <= SETUP;
                                cnt_r   <= SETUP_LD;
                            end else begin
                                state_r <= STROBE;
                                cnt_r   <= STROBE_LD;
                            end
                        end
                    end else begin
                        req_ready_r <= clr_next_s;
                    end
                end
                SETUP: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= STROBE;
                        cnt_r   <= STROBE_LD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                STROBE: begin
                    if (cnt_r == CNT_ZERO) begin
                        // Read data is taken while the strobe is still low.
                        if (!write_r) begin
                            rsp_rdata_r <= bus.db_in;
                        end
                        if (HOLD_CYC != 32'd0) begin
                            state_r <= HOLD;
                            cnt_r   <= HOLD_LD;
                        end else begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            db_oe_r     <= 1'b0;
                            if (write_r) begin
                                rsp_rdata_r <= 8'h00;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        db_oe_r     <= 1'b0;
                        if (write_r) begin
                            rsp_rdata_r <= 8'h00;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    req_ready_r <= clr_next_s;
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b0;
                    db_oe_r     <= 1'b0;
                end
            endcase
        end
    end

    cpu_io_strobe_decode u_strobe_decode (
        .clk       (clk),
        .rst       (rst),
        .port      (dec_port_s),
        .strobe_en (strobe_next_s),
        .strobe_al (strobe_al_s)
    );

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.db_out    = db_out_r;
    assign bus.db_oe     = db_oe_r;
    assign bus.clr_al    = clr_al_r;
    assign bus.in0_al    = strobe_al_s[0];
    assign bus.in1_al    = strobe_al_s[1];
    assign bus.in2_al    = strobe_al_s[2];
    assign bus.in3_al    = strobe_al_s[3];
    assign bus.in4_al    = strobe_al_s[4];
    assign bus.out1_al   = strobe_al_s[5];
    assign bus.out2_al   = strobe_al_s[6];

endmodule
